// File: rtl/cpu_ctrl_pkg.sv
// Package: cpu_ctrl_pkg
//   Shared types and constants for the bus control sequencer.
//   - opcode_t : instruction opcodes (op field IR[15:12])
//   - state_t  : sequencer states
//   - SEL_*    : fixed bus-source bit positions in src_sel
//   - sel_reg  : maps a register index k to its src_sel one-hot (bit 35-k)
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_MV  = 4'd0,
      OP_MVI = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_SIN = 4'd4,
      OP_COS = 4'd5
   } opcode_t;

   typedef enum logic [2:0] {
      T0    = 3'd0,
      T1    = 3'd1,
      T2    = 3'd2,
      T3    = 3'd3,
      CWAIT = 3'd4,
      CRES  = 3'd5
   } state_t;

   localparam int SEL_G   = 3;
   localparam int SEL_DIN = 2;
   localparam int SEL_SIN = 1;
   localparam int SEL_COS = 0;

   // Register sources occupy the top 32 bits, R0 at bit 35 down to R31 at bit 4.
   function automatic logic [35:0] sel_reg(input logic [4:0] k);
      logic [5:0] sh;
      sh      = 6'd35 - {1'b0, k};
      sel_reg = 36'b1 << sh;
   endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Module: reg_onehot_dec
//   Register index to one-hot load-enable decoder.
//   Ports:
//     idx    in  5   register index
//     en     in  1   decode enable; all-zero output when low
//     onehot out 32  bit idx set when en=1
module reg_onehot_dec (
   input  logic [4:0]  idx,
   input  logic        en,
   output logic [31:0] onehot
);

   assign onehot = en ? (32'b1 << idx) : 32'b0;

endmodule

// File: rtl/bus_control_fsm.sv
// Module: bus_control_fsm
//   Instruction sequencer for the shared 32-bit datapath bus. Drives one-hot
//   bus-source selects, one-hot register load enables, adder controls and the
//   CORDIC start/done handshake, and pulses Done as each instruction retires.
//   Optional feature macro: CTRL_TIMEOUT_EN (bounded CORDIC wait with
//   timeout_err); when undefined CWAIT waits indefinitely and timeout_err=0.
//   Handshake: Run is a request sampled only in T0; cordic_start is a one-cycle
//   pulse with the angle on the bus; cordic_done is honoured only in CWAIT.
//   Ports:
//     Clock, Resetn           clock (rising edge), async active-low reset
//     Run                     start request
//     IR [IR_W]               op[15:12], rx[11:7], ry[6:2]
//     cordic_done             CORDIC result valid
//     src_sel [36]            one-hot bus source
//     reg_in [32]             one-hot register load enables
//     IRin, Ain, Gin, AddSub  IR load, adder operand/result load, add/sub
//     cordic_start            CORDIC start pulse
//     Done                    retire pulse
//     illegal_op, timeout_err error pulses (coincide with Done)
//     fsm_state [3]           current state (debug observation)
module bus_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int IR_W           = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic            Run,
   input  logic [IR_W-1:0] IR,
   input  logic            cordic_done,
   output logic [35:0]     src_sel,
   output logic [31:0]     reg_in,
   output logic            IRin,
   output logic            Ain,
   output logic            Gin,
   output logic            AddSub,
   output logic            cordic_start,
   output logic            Done,
   output logic            illegal_op,
   output logic            timeout_err,
   output logic [2:0]      fsm_state
);

   state_t     state;
   opcode_t    op;
   logic [4:0] rx, ry;
   logic       unused_ir;
   logic       tmo_hit;

   logic [35:0] src_c;
   logic        rx_load_c, irin_c, ain_c, gin_c, addsub_c, cstart_c;
   logic        done_c, ill_c, tmo_c;

   assign op        = opcode_t'(IR[15:12]);
   assign rx        = IR[11:7];
   assign ry        = IR[6:2];
   assign unused_ir = ^IR[1:0];
   assign fsm_state = state;

`ifdef CTRL_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] wait_cnt;

   // Held at zero outside CWAIT, so it is already clear on CWAIT entry.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         wait_cnt <= '0;
      else if (state != CWAIT)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign tmo_hit = (state == CWAIT) && !cordic_done &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= T0;
      end else begin
         case (state)
            T0:    if (Run) state <= T1;
            T1: begin
               case (op)
                  OP_ADD, OP_SUB: state <= T2;
                  OP_SIN, OP_COS: state <= CWAIT;
                  default:        state <= T0;
               endcase
            end
            T2:    state <= T3;
            T3:    state <= T0;
            // cordic_done wins over a timeout in the same cycle.
            CWAIT: begin
               if (cordic_done)  state <= CRES;
               else if (tmo_hit) state <= T0;
            end
            CRES:  state <= T0;
            default: state <= T0;
         endcase
      end
   end

   always_comb begin
      src_c     = 36'b0;
      rx_load_c = 1'b0;
      irin_c    = 1'b0;
      ain_c     = 1'b0;
      gin_c     = 1'b0;
      addsub_c  = 1'b0;
      cstart_c  = 1'b0;
      done_c    = 1'b0;
      ill_c     = 1'b0;
      tmo_c     = 1'b0;
      case (state)
         T0: begin
            if (Run) begin
               src_c  = 36'b1 << SEL_DIN;
               irin_c = 1'b1;
            end
         end
         T1: begin
            case (op)
               OP_MV: begin
                  src_c     = sel_reg(ry);
                  rx_load_c = 1'b1;
                  done_c    = 1'b1;
               end
               OP_MVI: begin
                  src_c     = 36'b1 << SEL_DIN;
                  rx_load_c = 1'b1;
                  done_c    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  src_c = sel_reg(rx);
                  ain_c = 1'b1;
               end
               OP_SIN, OP_COS: begin
                  src_c    = sel_reg(ry);
                  cstart_c = 1'b1;
               end
               default: begin
                  done_c = 1'b1;
                  ill_c  = 1'b1;
               end
            endcase
         end
         T2: begin
            src_c    = sel_reg(ry);
            gin_c    = 1'b1;
            addsub_c = IR[12];
         end
         T3: begin
            src_c     = 36'b1 << SEL_G;
            rx_load_c = 1'b1;
            done_c    = 1'b1;
         end
         CWAIT: begin
            done_c = tmo_hit;
            tmo_c  = tmo_hit;
         end
         CRES: begin
            src_c     = (op == OP_SIN) ? (36'b1 << SEL_SIN) : (36'b1 << SEL_COS);
            rx_load_c = 1'b1;
            done_c    = 1'b1;
         end
         default: ;
      endcase
   end

   // Every output is forced low while reset is held, including the T0/Run path.
   reg_onehot_dec u_reg_in_dec (
      .idx    (rx),
      .en     (rx_load_c & Resetn),
      .onehot (reg_in)
   );

   assign src_sel      = Resetn ? src_c : 36'b0;
   assign IRin         = Resetn & irin_c;
   assign Ain          = Resetn & ain_c;
   assign Gin          = Resetn & gin_c;
   assign AddSub       = Resetn & addsub_c;
   assign cordic_start = Resetn & cstart_c;
   assign Done         = Resetn & done_c;
   assign illegal_op   = Resetn & ill_c;
   assign timeout_err  = Resetn & tmo_c;

endmodule

// File: tb/tb_bus_control_fsm.sv
// Testbench: tb_bus_control_fsm
//   Randomized and directed instruction streams for bus_control_fsm. An
//   instruction-level model expands each instruction into its expected
//   per-cycle output vectors from the opcode rules; the DUT is compared every
//   cycle. Build with +define+CTRL_TIMEOUT_EN to include CORDIC timeouts.
module tb_bus_control_fsm;
   import cpu_ctrl_pkg::*;

   localparam int TO    = 64;
   localparam int EXP_W = 76;  // {src_sel[36], reg_in[32], ctl[8]}

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        Run = 1'b0;
   logic [15:0] IR = 16'h0;
   logic        cordic_done = 1'b0;
   logic [35:0] src_sel;
   logic [31:0] reg_in;
   logic        IRin, Ain, Gin, AddSub, cordic_start, Done, illegal_op, timeout_err;
   logic [2:0]  fsm_state;

   int errors = 0;
   int checks = 0;

   logic [EXP_W-1:0] exp_q[$];
   logic             run_q[$];
   logic             cd_q[$];
   logic [15:0]      ir_q[$];

   bus_control_fsm #(.IR_W(16), .TIMEOUT_CYCLES(TO)) dut (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .Run          (Run),
      .IR           (IR),
      .cordic_done  (cordic_done),
      .src_sel      (src_sel),
      .reg_in       (reg_in),
      .IRin         (IRin),
      .Ain          (Ain),
      .Gin          (Gin),
      .AddSub       (AddSub),
      .cordic_start (cordic_start),
      .Done         (Done),
      .illegal_op   (illegal_op),
      .timeout_err  (timeout_err),
      .fsm_state    (fsm_state)
   );

   // clock
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ctl bit order: IRin, Ain, Gin, AddSub, cordic_start, Done, illegal_op, timeout_err
   function automatic logic [7:0] ctl_obs();
      return {IRin, Ain, Gin, AddSub, cordic_start, Done, illegal_op, timeout_err};
   endfunction

   function automatic logic [35:0] src_of_reg(input int k);
      logic [35:0] one;
      one = 36'b1;
      return one << (35 - k);
   endfunction

   function automatic logic [31:0] load_of_reg(input int k);
      logic [31:0] one;
      one = 32'b1;
      return one << k;
   endfunction

   task automatic push(input logic [15:0] ir, input logic run, input logic cd,
                       input logic [35:0] src, input logic [31:0] ld, input logic [7:0] ctl);
      ir_q.push_back(ir);
      run_q.push_back(run);
      cd_q.push_back(cd);
      exp_q.push_back({src, ld, ctl});
   endtask

   // Reference model: expands one instruction into its cycle-by-cycle outputs.
   // w = cycle index within CWAIT (1-based) on which cordic_done is raised.
   task automatic add_instr(input int op, input int rx, input int ry, input int w);
      logic [15:0] ir;
      logic [1:0]  pad;
      pad = 2'($urandom_range(0, 3));
      ir  = {4'(op), 5'(rx), 5'(ry), pad};
      // T0 fetch: DIN onto the bus, load IR
      push(ir, 1'b1, 1'($urandom_range(0, 1)), 36'h4, 32'h0, 8'b1000_0000);
      case (op)
         0: push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 src_of_reg(ry), load_of_reg(rx), 8'b0000_0100);
         1: push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 36'h4, load_of_reg(rx), 8'b0000_0100);
         2, 3: begin
            push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 src_of_reg(rx), 32'h0, 8'b0100_0000);
            push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 src_of_reg(ry), 32'h0, (op == 3) ? 8'b0011_0000 : 8'b0010_0000);
            push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 36'h8, load_of_reg(rx), 8'b0000_0100);
         end
         4, 5: begin
            // cordic_done is random here: it must be ignored in the start cycle
            push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 src_of_reg(ry), 32'h0, 8'b0000_1000);
            for (int i = 1; i <= w; i++) begin
               if (i == w) begin
                  push(ir, 1'($urandom_range(0, 1)), 1'b1, 36'h0, 32'h0, 8'h0);
                  push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       (op == 4) ? 36'h2 : 36'h1, load_of_reg(rx), 8'b0000_0100);
               end
`ifdef CTRL_TIMEOUT_EN
               else if (i == TO) begin
                  push(ir, 1'($urandom_range(0, 1)), 1'b0, 36'h0, 32'h0, 8'b0000_0101);
                  break;
               end
`endif
               else begin
                  push(ir, 1'($urandom_range(0, 1)), 1'b0, 36'h0, 32'h0, 8'h0);
               end
            end
         end
         default: push(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       36'h0, 32'h0, 8'b0000_0110);
      endcase
   endtask

   task automatic add_idle();
      push(16'($urandom()), 1'b0, 1'($urandom_range(0, 1)), 36'h0, 32'h0, 8'h0);
   endtask

   // driver + scoreboard: drive at negedge, compare after settling
   task automatic run_queue();
      logic [EXP_W-1:0] e;
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge Clock);
         Run         = run_q.pop_front();
         IR          = ir_q.pop_front();
         cordic_done = cd_q.pop_front();
         #1;
         e = exp_q.pop_front();
         check($sformatf("src_sel c%0d ir=%h", cyc, IR), 64'(src_sel), 64'(e[75:40]));
         check($sformatf("reg_in c%0d ir=%h", cyc, IR), 64'(reg_in), 64'(e[39:8]));
         check($sformatf("ctl c%0d ir=%h", cyc, IR), 64'(ctl_obs()), 64'(e[7:0]));
         cyc++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " src_sel"}, 64'(src_sel), 64'h0);
      check({tag, " reg_in"}, 64'(reg_in), 64'h0);
      check({tag, " ctl"}, 64'(ctl_obs()), 64'h0);
   endtask

   initial begin
      int op, w;
      // reset state, with Run high to show outputs are forced low
      Resetn = 1'b0;
      Run    = 1'b1;
      IR     = 16'h2000;
      repeat (2) @(negedge Clock);
      #1;
      check_all_zero("reset");
      check("reset state", 64'(fsm_state), 64'(T0));
      @(negedge Clock);
      Resetn = 1'b1;
      Run    = 1'b0;
      #1;
      check_all_zero("idle after reset");

      // mvi R5 and sub R3,R31
      add_instr(1, 5, 0, 0);
      add_idle();
      add_instr(3, 3, 31, 0);
      add_idle();
      // cos R0,R1 with done after 7 CWAIT cycles
      add_instr(5, 0, 1, 7);
      add_idle();
      // illegal opcode then back-to-back mv (Run held high)
      add_instr(15, 2, 3, 0);
      add_instr(0, 4, 4, 0);
      // add doubling a register, sin
      add_instr(2, 9, 9, 0);
      add_instr(4, 31, 17, 1);
      add_idle();
      run_queue();

      // reset mid-add while in T2
      add_instr(2, 6, 7, 0);
      void'(exp_q.pop_back()); void'(run_q.pop_back());
      void'(cd_q.pop_back());  void'(ir_q.pop_back());
      void'(exp_q.pop_back()); void'(run_q.pop_back());
      void'(cd_q.pop_back());  void'(ir_q.pop_back());
      run_queue();
      @(negedge Clock);
      Resetn = 1'b0;
      #1;
      check_all_zero("reset in T2");
      @(negedge Clock);
      Resetn = 1'b1;
      Run    = 1'b0;
      #1;
      check_all_zero("after mid reset");
      check("state after mid reset", 64'(fsm_state), 64'(T0));
      add_instr(2, 6, 7, 0);
      add_idle();

`ifdef CTRL_TIMEOUT_EN
      add_instr(4, 1, 2, TO + 20);  // never answered -> timeout
      add_instr(5, 3, 4, TO);       // done on the last allowed cycle wins
      add_idle();
`endif

      // random instruction stream
      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 5));
         w  = int'($urandom_range(1, 10));
`ifdef CTRL_TIMEOUT_EN
         if ($urandom_range(0, 9) == 0) w = TO + int'($urandom_range(0, 4));
`endif
         add_instr(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), w);
         if ($urandom_range(0, 1) == 1) add_idle();
      end
      add_idle();
      run_queue();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // global time bound
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
